// File: rtl/committed_store_buffer_pkg.sv
// committed_store_buffer_pkg: shared LSQ types for the post-commit store buffer
package committed_store_buffer_pkg;
  localparam int CSB_ENTRY_NUM = 8;
  localparam int CSB_ENQ_WIDTH = 2;
  localparam int CSB_LOAD_PORT_NUM = 2;
  localparam int CSB_BLOCK_BYTE_NUM = 8;
  localparam int CSB_ADDR_WIDTH = 29;
  localparam int CSB_DRAIN_THRESHOLD = 6;
  localparam int CSB_TIMEOUT = 15;
  typedef logic [$clog2(CSB_ENTRY_NUM)-1:0] CSB_IndexPath;
  typedef logic [$clog2(CSB_ENTRY_NUM+1)-1:0] CSB_CountPath;
  typedef struct packed {
    logic [CSB_ADDR_WIDTH-1:0] addr;
    logic [CSB_BLOCK_BYTE_NUM-1:0] byteWE;
    logic [CSB_BLOCK_BYTE_NUM*8-1:0] data;
  } CSB_EntryPath;
  typedef enum logic {CSB_IDLE, CSB_OFFER} CSB_DrainState;
endpackage

// File: rtl/committed_store_buffer_forward_merger.sv
// csb_forward_merger: age-ordered byte merge of buffer entries for one load lookup
module csb_forward_merger
  import committed_store_buffer_pkg::*;
#(
  parameter int ENTRY_NUM = CSB_ENTRY_NUM,
  parameter int BLOCK_BYTE_NUM = CSB_BLOCK_BYTE_NUM,
  parameter int ADDR_WIDTH = CSB_ADDR_WIDTH
) (
  input  logic [$clog2(ENTRY_NUM)-1:0] headPtr,
  input  logic [ENTRY_NUM-1:0] entValid,
  input  logic [ENTRY_NUM-1:0][ADDR_WIDTH-1:0] entAddr,
  input  logic [ENTRY_NUM-1:0][BLOCK_BYTE_NUM-1:0] entWE,
  input  logic [ENTRY_NUM-1:0][BLOCK_BYTE_NUM*8-1:0] entData,
  input  logic [ADDR_WIDTH-1:0] ldAddr,
  input  logic [BLOCK_BYTE_NUM-1:0] ldByteRE,
  output logic [BLOCK_BYTE_NUM-1:0] hitMask,
  output logic [BLOCK_BYTE_NUM*8-1:0] fwdData,
  output logic fwdFull
);
  localparam int IW = $clog2(ENTRY_NUM);
  logic [IW-1:0] idx;
  // walking oldest to youngest lets later writers overwrite earlier ones per byte
  always_comb begin
    hitMask = '0;
    fwdData = '0;
    idx = headPtr;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      idx = headPtr + IW'(k);
      for (int b = 0; b < BLOCK_BYTE_NUM; b++)
        if (entValid[idx] && entAddr[idx] == ldAddr && entWE[idx][b] && ldByteRE[b]) begin
          hitMask[b] = 1'b1;
          fwdData[b*8 +: 8] = entData[idx][b*8 +: 8];
        end
    end
  end
  assign fwdFull = (hitMask == ldByteRE) && |ldByteRE;
endmodule

// File: rtl/committed_store_buffer.sv
// committed_store_buffer: coalescing post-commit store buffer draining oldest-first to the cache
module committed_store_buffer
  import committed_store_buffer_pkg::*;
#(
  parameter int ENTRY_NUM = CSB_ENTRY_NUM,
  parameter int ENQ_WIDTH = CSB_ENQ_WIDTH,
  parameter int LOAD_PORT_NUM = CSB_LOAD_PORT_NUM,
  parameter int BLOCK_BYTE_NUM = CSB_BLOCK_BYTE_NUM,
  parameter int ADDR_WIDTH = CSB_ADDR_WIDTH,
  parameter int DRAIN_THRESHOLD = CSB_DRAIN_THRESHOLD,
  parameter int TIMEOUT = CSB_TIMEOUT
) (
  input  logic clk,
  input  logic rstN,
  input  logic [ENQ_WIDTH-1:0] enqValid,
  input  logic [ENQ_WIDTH-1:0][ADDR_WIDTH-1:0] enqAddr,
  input  logic [ENQ_WIDTH-1:0][BLOCK_BYTE_NUM-1:0] enqByteWE,
  input  logic [ENQ_WIDTH-1:0][BLOCK_BYTE_NUM*8-1:0] enqData,
  output logic enqReady,
  output logic drainValid,
  output logic [ADDR_WIDTH-1:0] drainAddr,
  output logic [BLOCK_BYTE_NUM-1:0] drainByteWE,
  output logic [BLOCK_BYTE_NUM*8-1:0] drainData,
  input  logic drainReady,
  input  logic flushReq,
  output logic flushDone,
  input  logic [LOAD_PORT_NUM-1:0][ADDR_WIDTH-1:0] ldAddr,
  input  logic [LOAD_PORT_NUM-1:0][BLOCK_BYTE_NUM-1:0] ldByteRE,
  output logic [LOAD_PORT_NUM-1:0][BLOCK_BYTE_NUM-1:0] fwdHitMask,
  output logic [LOAD_PORT_NUM-1:0][BLOCK_BYTE_NUM*8-1:0] fwdData,
  output logic [LOAD_PORT_NUM-1:0] fwdFull,
  output logic [$clog2(ENTRY_NUM+1)-1:0] count
);
  localparam int IW = $clog2(ENTRY_NUM);
  localparam int CW = $clog2(ENTRY_NUM+1);
  localparam int TW = $clog2(TIMEOUT+1);
  logic [ENTRY_NUM-1:0] entValid, nValid;
  logic [ENTRY_NUM-1:0][ADDR_WIDTH-1:0] entAddr, nAddr;
  logic [ENTRY_NUM-1:0][BLOCK_BYTE_NUM-1:0] entWE, nWE;
  logic [ENTRY_NUM-1:0][BLOCK_BYTE_NUM*8-1:0] entData, nData;
  logic [IW-1:0] headPtr, tailPtr, slot, m, tgt, idx;
  logic [CW-1:0] allocCnt, countNext;
  logic [TW-1:0] idleCnt;
  logic hit, coal, anyEnq, pop, startIdle, startNext;
  CSB_DrainState state;
  assign drainValid = state == CSB_OFFER;
  assign pop = drainValid && drainReady;
  assign enqReady = (ENTRY_NUM - int'(count)) >= ENQ_WIDTH;
  assign drainAddr = entAddr[headPtr];
  assign drainByteWE = entWE[headPtr];
  assign drainData = entData[headPtr];
  assign flushDone = flushReq && count == '0;
  // merge targets come from start-of-cycle state so lanes never coalesce with each other
  always_comb begin
    nValid = entValid;
    nAddr = entAddr;
    nWE = entWE;
    nData = entData;
    slot = tailPtr;
    allocCnt = '0;
    anyEnq = 1'b0;
    hit = 1'b0;
    coal = 1'b0;
    m = '0;
    tgt = '0;
    idx = '0;
    for (int l = 0; l < ENQ_WIDTH; l++) begin
      hit = 1'b0;
      for (int k = 0; k < ENTRY_NUM; k++) begin
        idx = headPtr + IW'(k);
        if (entValid[idx] && entAddr[idx] == enqAddr[l]) begin
          hit = 1'b1;
          m = idx;
        end
      end
      coal = hit && !(m == headPtr && drainValid);
      tgt = coal ? m : slot;
      if (enqValid[l] && enqReady) begin
        anyEnq = 1'b1;
        nValid[tgt] = 1'b1;
        nAddr[tgt] = enqAddr[l];
        if (!coal) begin
          nWE[tgt] = '0;
          nData[tgt] = '0;
        end
        nWE[tgt] = nWE[tgt] | enqByteWE[l];
        for (int b = 0; b < BLOCK_BYTE_NUM; b++)
          if (enqByteWE[l][b]) nData[tgt][b*8 +: 8] = enqData[l][b*8 +: 8];
        if (!coal) begin
          slot = slot + IW'(1);
          allocCnt = allocCnt + CW'(1);
        end
      end
    end
    if (pop) nValid[headPtr] = 1'b0;
  end
  assign countNext = count + allocCnt - CW'(pop);
  assign startIdle = count >= CW'(DRAIN_THRESHOLD) || (idleCnt == TW'(TIMEOUT) && count != '0) ||
                     (flushReq && count != '0);
  // after a pop idleCnt is cleared, so only occupancy and flush can keep the drain going
  assign startNext = countNext >= CW'(DRAIN_THRESHOLD) || (flushReq && countNext != '0);
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      entValid <= '0;
      entAddr <= '0;
      entWE <= '0;
      entData <= '0;
      headPtr <= '0;
      tailPtr <= '0;
      count <= '0;
      idleCnt <= '0;
      state <= CSB_IDLE;
    end else begin
      entValid <= nValid;
      entAddr <= nAddr;
      entWE <= nWE;
      entData <= nData;
      headPtr <= headPtr + IW'(pop);
      tailPtr <= slot;
      count <= countNext;
      idleCnt <= (anyEnq || pop) ? '0 :
                 (count != '0 && idleCnt != TW'(TIMEOUT)) ? idleCnt + TW'(1) : idleCnt;
      state <= (state == CSB_IDLE) ? (startIdle ? CSB_OFFER : CSB_IDLE) :
               (pop ? (startNext ? CSB_OFFER : CSB_IDLE) : CSB_OFFER);
    end
  end
  for (genvar p = 0; p < LOAD_PORT_NUM; p++) begin : gFwd
    csb_forward_merger #(
      .ENTRY_NUM(ENTRY_NUM),
      .BLOCK_BYTE_NUM(BLOCK_BYTE_NUM),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) uMerge (
      .headPtr(headPtr),
      .entValid(entValid),
      .entAddr(entAddr),
      .entWE(entWE),
      .entData(entData),
      .ldAddr(ldAddr[p]),
      .ldByteRE(ldByteRE[p]),
      .hitMask(fwdHitMask[p]),
      .fwdData(fwdData[p]),
      .fwdFull(fwdFull[p])
    );
  end
endmodule
